// File: rtl/bitsum_driver_if.sv
// Handshake bundle between the bitsum driver, its upstream/downstream ports and the engine.
// The master modport is the driver; the slave modport is everything around it.
interface bitsum_driver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             eng_start;
    logic [WIDTH-1:0] eng_in;
    logic             eng_finish;
    logic [31:0]      eng_result;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;

    modport master (
        input  in_valid, in_data, eng_finish, eng_result, res_ready,
        output in_ready, eng_start, eng_in, res_valid, res_data
    );

    modport slave (
        output in_valid, in_data, eng_finish, eng_result, res_ready,
        input  in_ready, eng_start, eng_in, res_valid, res_data
    );
endinterface

// File: rtl/bitsum_driver.sv
// Start/finish initiator for a bitsum engine: FIFO-buffered words in, one result per word out,
// with a saturating running total and a sticky timeout flag for engines that never answer.
module bitsum_driver #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    bitsum_driver_if.master        bus,
    output logic [31:0]            total,
    output logic [15:0]            done_cnt,
    output logic                   timeout_err,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, START, WAIT, SETTLE, EMIT} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] eng_in_q, eng_in_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [31:0]      total_q, total_d;
    logic [15:0]      done_q, done_d;
    logic             err_q, err_d;
    logic             finish_q;
    logic [32:0]      sum;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop, rise;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign push  = bus.in_valid && !full;
    assign rise  = bus.eng_finish && !finish_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        eng_in_d   = eng_in_q;
        res_data_d = res_data_q;
        total_d    = total_q;
        done_d     = done_q;
        err_d      = err_q;
        pop        = 1'b0;
        sum        = {1'b0, total_q} + {1'b0, bus.eng_result};
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    eng_in_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d  = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (rise) begin
                    state_d = SETTLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                res_data_d = bus.eng_result;
                total_d    = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
                done_d     = done_q + 16'd1;
                state_d    = EMIT;
            end
            EMIT: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            eng_in_q   <= '0;
            res_data_q <= '0;
            total_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            finish_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            eng_in_q   <= eng_in_d;
            res_data_q <= res_data_d;
            total_q    <= total_d;
            done_q     <= done_d;
            err_q      <= err_d;
            finish_q   <= bus.eng_finish;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready  = !full;
    assign bus.eng_start = (state_q == START);
    assign bus.eng_in    = eng_in_q;
    assign bus.res_valid = (state_q == EMIT);
    assign bus.res_data  = res_data_q;
    assign total         = total_q;
    assign done_cnt      = done_q;
    assign timeout_err   = err_q;
    assign busy          = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_bitsum_driver.sv
// Directed bench for bitsum_driver with a behavioural popcount engine (finish latency L=3).
module tb_bitsum_driver;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] total;
    logic [15:0] done_cnt;
    logic        timeout_err;
    logic        busy;

    int   mode = 0;          // 0 popcount, 1 silent engine, 2 constant 0xFFFFFFF0, 3 manual finish
    logic fin_eng = 1'b0;
    logic fin_man = 1'b0;
    int   k = 0;
    int   n_total = 0;
    int   n_bad = 0;

    bitsum_driver_if #(.WIDTH(32)) bus();

    bitsum_driver #(.WIDTH(32), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .bus(bus), .total(total),
        .done_cnt(done_cnt), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine raises finish L cycles after the start cycle and holds it until the next start.
    always @(posedge clk) begin
        if (bus.eng_start) begin
            fin_eng <= (L == 1);
            k       <= 1;
        end else if (k != 0 && k < L) begin
            if (k + 1 == L) fin_eng <= 1'b1;
            k <= k + 1;
        end
    end

    assign bus.eng_finish = (mode == 3) ? fin_man : (mode == 1) ? 1'b0 : fin_eng;
    assign bus.eng_result = (mode == 2) ? 32'hFFFF_FFF0 : 32'($countones(bus.eng_in));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rv(input string tag);
        int n = 0;
        while (!bus.res_valid && n < 60) begin step(); n++; end
        chk(tag, 32'(bus.res_valid), 32'd1);
    endtask

    task automatic wait_st(input string tag);
        int n = 0;
        while (!bus.eng_start && n < 20) begin step(); n++; end
        chk(tag, 32'(bus.eng_start), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;

        // Reset and idle behaviour
        step();
        step();
        chk("rst_start", 32'(bus.eng_start), 32'd0);
        chk("rst_rvalid", 32'(bus.res_valid), 32'd0);
        chk("rst_rdata", bus.res_data, 32'd0);
        chk("rst_engin", bus.eng_in, 32'd0);
        chk("rst_total", total, 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_nostart", 32'(bus.eng_start), 32'd0);
        end
        mode = 3;
        fin_man = 1'b0;
        step();
        fin_man = 1'b1;
        step();
        step();
        chk("spurious_busy", 32'(busy), 32'd0);
        chk("spurious_done", 32'(done_cnt), 32'd0);

        // Single word, latency L+4 from push to res_valid
        mode = 0;
        do_reset();
        bus.res_ready = 1'b1;
        push(32'hFFFF_FFFF);
        chk("t1_start", 32'(bus.eng_start), 32'd0);
        step();
        chk("t2_start", 32'(bus.eng_start), 32'd1);
        chk("t2_engin", bus.eng_in, 32'hFFFF_FFFF);
        for (int i = 3; i <= 6; i++) begin
            step();
            chk("hold_engin", bus.eng_in, 32'hFFFF_FFFF);
            chk("early_rvalid", 32'(bus.res_valid), 32'd0);
            chk("one_pulse", 32'(bus.eng_start), 32'd0);
        end
        step();
        chk("t7_rvalid", 32'(bus.res_valid), 32'd1);
        chk("t7_rdata", bus.res_data, 32'd32);
        chk("t7_total", total, 32'd32);
        chk("t7_done", 32'(done_cnt), 32'd1);
        step();
        chk("t8_rvalid", 32'(bus.res_valid), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);

        // Backpressure and FIFO full
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_inready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = (32'd1 << i) - 32'd1;
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        wait_rv("bp_first_rv");
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_rv", 32'(bus.res_valid), 32'd1);
            chk("bp_hold_data", bus.res_data, 32'd0);
            step();
        end
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rv("bp_rv");
            chk("bp_order", bus.res_data, 32'(i));
            step();
        end
        chk("bp_total", total, 32'd10);
        chk("bp_done", 32'(done_cnt), 32'd5);

        // Timeout with a silent engine
        do_reset();
        mode = 1;
        push(32'h1234_5678);
        wait_st("to_start");
        for (int i = 0; i < 63; i++) step();
        chk("to_not_yet", 32'(timeout_err), 32'd0);
        step();
        step();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_rv", 32'(bus.res_valid), 32'd0);
        chk("to_total", total, 32'd0);
        chk("to_done", 32'(done_cnt), 32'd0);
        mode = 0;
        push(32'h00FF_00FF);
        wait_rv("to_next_rv");
        chk("to_next_data", bus.res_data, 32'd16);
        chk("to_next_total", total, 32'd16);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Stale finish must fall and rise again
        do_reset();
        mode = 3;
        fin_man = 1'b1;
        step();
        push(32'h0000_0007);
        wait_st("st_start");
        for (int i = 0; i < 5; i++) step();
        chk("st_no_rv", 32'(bus.res_valid), 32'd0);
        chk("st_busy", 32'(busy), 32'd1);
        fin_man = 1'b0;
        step();
        step();
        fin_man = 1'b1;
        step();
        chk("st_settle_rv", 32'(bus.res_valid), 32'd0);
        step();
        chk("st_rv", 32'(bus.res_valid), 32'd1);
        chk("st_data", bus.res_data, 32'd3);
        step();

        // Mid-WAIT reset after a timeout, with a word still queued
        fin_man = 1'b0;
        push(32'h1);
        push(32'h3);
        begin
            int n = 0;
            while (!timeout_err && n < 100) begin step(); n++; end
        end
        chk("mr_err_set", 32'(timeout_err), 32'd1);
        wait_st("mr_start");
        step();
        step();
        push(32'h5);
        rst = 1'b0;
        step();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_err", 32'(timeout_err), 32'd0);
        chk("mr_engin", bus.eng_in, 32'd0);
        chk("mr_total", total, 32'd0);
        chk("mr_done", 32'(done_cnt), 32'd0);
        chk("mr_rdata", bus.res_data, 32'd0);
        chk("mr_inready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        step();
        chk("mr_fifo_empty", 32'(bus.eng_start), 32'd0);

        // Saturating total
        do_reset();
        mode = 2;
        push(32'hA);
        push(32'hB);
        wait_rv("sat_rv1");
        chk("sat_data1", bus.res_data, 32'hFFFF_FFF0);
        chk("sat_total1", total, 32'hFFFF_FFF0);
        step();
        wait_rv("sat_rv2");
        chk("sat_total2", total, 32'hFFFF_FFFF);
        chk("sat_done2", 32'(done_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
